// File: rtl/kf_in_service_tracker_if.sv
// Bus between the interrupt controller core and its in-service tracker.
// The master side issues acknowledge/EOI commands; the slave side (the tracker) reports ISR state.
interface kf_in_service_tracker_if #(
  parameter int unsigned NUM_LEVELS = 8,
  parameter int unsigned PTR_W      = $clog2(NUM_LEVELS)
);
  logic                  ack_valid;
  logic [PTR_W-1:0]      ack_level;
  logic                  auto_eoi;
  logic                  auto_rotate;
  logic                  eoi_valid;
  logic [2:0]            eoi_cmd;
  logic [PTR_W-1:0]      eoi_level;
  logic [NUM_LEVELS-1:0] special_mask;
  logic [NUM_LEVELS-1:0] in_service_register;
  logic [NUM_LEVELS-1:0] highest_level_in_service;
  logic [PTR_W-1:0]      priority_pointer;
  logic                  isr_empty;
  logic                  cmd_error;

  modport master (
    output ack_valid, ack_level, auto_eoi, auto_rotate,
    output eoi_valid, eoi_cmd, eoi_level, special_mask,
    input  in_service_register, highest_level_in_service, priority_pointer,
    input  isr_empty, cmd_error
  );

  modport slave (
    input  ack_valid, ack_level, auto_eoi, auto_rotate,
    input  eoi_valid, eoi_cmd, eoi_level, special_mask,
    output in_service_register, highest_level_in_service, priority_pointer,
    output isr_empty, cmd_error
  );
endinterface

// File: rtl/kf_in_service_tracker.sv
// In-service register tracker: sets ISR bits on acknowledge, clears them on EOI,
// owns the rotating-priority pointer and publishes the registered highest in-service level.
module kf_in_service_tracker #(
  parameter int unsigned NUM_LEVELS = 8,
  parameter int unsigned PTR_W      = $clog2(NUM_LEVELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  kf_in_service_tracker_if.slave    bus
);

  logic [NUM_LEVELS-1:0] isr_q, isr_d;
  logic [NUM_LEVELS-1:0] hls_q, hls_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  empty_q, empty_d;
  logic                  err_q, err_d;

  logic                  ack_ok, eoi_ok;
  logic [NUM_LEVELS-1:0] ack_hot, sp_hot, ns_hot;
  logic [NUM_LEVELS-1:0] eoi_clr, ack_set;
  logic                  ptr_upd;
  logic [PTR_W-1:0]      ptr_val;

  // First set bit of v walking pointer+1, pointer+2, ... modulo NUM_LEVELS.
  function automatic logic [NUM_LEVELS-1:0] resolve(input logic [NUM_LEVELS-1:0] v,
                                                    input logic [PTR_W-1:0]      ptr);
    logic        found;
    int unsigned idx;
    resolve = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
      idx = 32'(ptr) + i + 1;
      if (idx >= NUM_LEVELS) idx = idx - NUM_LEVELS;
      if (!found && v[idx[PTR_W-1:0]]) begin
        resolve[idx[PTR_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  endfunction

  function automatic logic [PTR_W-1:0] encode(input logic [NUM_LEVELS-1:0] hot);
    encode = '0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
      if (hot[i]) encode = PTR_W'(i);
    end
  endfunction

  always_comb begin
    ack_ok  = 32'(bus.ack_level) < NUM_LEVELS;
    eoi_ok  = 32'(bus.eoi_level) < NUM_LEVELS;
    ack_hot = NUM_LEVELS'(1) << bus.ack_level;
    sp_hot  = NUM_LEVELS'(1) << bus.eoi_level;
    ns_hot  = resolve(isr_q, ptr_q);
    eoi_clr = '0;
    ack_set = '0;
    ptr_upd = 1'b0;
    ptr_val = ptr_q;
    err_d   = 1'b0;

    if (bus.ack_valid) begin
      if (!ack_ok)            err_d   = 1'b1;
      else if (!bus.auto_eoi) ack_set = ack_hot;
    end

    if (bus.eoi_valid) begin
      case (bus.eoi_cmd)
        3'b001, 3'b101: begin
          if (ns_hot != '0) begin
            eoi_clr = ns_hot;
            if (bus.eoi_cmd[2]) begin
              ptr_upd = 1'b1;
              ptr_val = encode(ns_hot);
            end
          end
        end
        3'b011, 3'b111: begin
          if (!eoi_ok || (isr_q & sp_hot) == '0) begin
            err_d = 1'b1;
          end else begin
            eoi_clr = sp_hot;
            if (bus.eoi_cmd[2]) begin
              ptr_upd = 1'b1;
              ptr_val = bus.eoi_level;
            end
          end
        end
        3'b110: begin
          if (!eoi_ok) begin
            err_d = 1'b1;
          end else begin
            ptr_upd = 1'b1;
            ptr_val = bus.eoi_level;
          end
        end
        default: ;
      endcase
    end

    // Clear before set: an ack landing on the EOI target leaves the bit set.
    isr_d = (isr_q & ~eoi_clr) | ack_set;

    if (ptr_upd)
      ptr_d = ptr_val;
    else if (bus.ack_valid && ack_ok && bus.auto_eoi && bus.auto_rotate)
      ptr_d = bus.ack_level;
    else
      ptr_d = ptr_q;

    hls_d   = resolve(isr_d & ~bus.special_mask, ptr_d);
    empty_d = (isr_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      isr_q   <= '0;
      hls_q   <= '0;
      ptr_q   <= PTR_W'(NUM_LEVELS - 1);
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      isr_q   <= isr_d;
      hls_q   <= hls_d;
      ptr_q   <= ptr_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_service_register      = isr_q;
  assign bus.highest_level_in_service = hls_q;
  assign bus.priority_pointer         = ptr_q;
  assign bus.isr_empty                = empty_q;
  assign bus.cmd_error                = err_q;

endmodule

// File: tb/tb_kf_in_service_tracker.sv
// Directed bench for kf_in_service_tracker at NUM_LEVELS=8 and NUM_LEVELS=5.
// The driver queues hand-computed expectations; a monitor compares them after each clock edge.
module tb_kf_in_service_tracker;

  logic clock;
  logic reset;

  kf_in_service_tracker_if #(.NUM_LEVELS(8)) ia ();
  kf_in_service_tracker_if #(.NUM_LEVELS(5)) ib ();

  kf_in_service_tracker #(.NUM_LEVELS(8)) dut_a (.clock(clock), .reset(reset), .bus(ia));
  kf_in_service_tracker #(.NUM_LEVELS(5)) dut_b (.clock(clock), .reset(reset), .bus(ib));

  typedef struct {
    int          sel;
    logic [31:0] isr;
    logic [31:0] hls;
    logic [4:0]  ptr;
    logic        empty;
    logic        err;
    string       name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic idle_a();
    ia.ack_valid = 1'b0; ia.ack_level = '0; ia.auto_eoi = 1'b0; ia.auto_rotate = 1'b0;
    ia.eoi_valid = 1'b0; ia.eoi_cmd = '0; ia.eoi_level = '0; ia.special_mask = '0;
  endtask

  task automatic idle_b();
    ib.ack_valid = 1'b0; ib.ack_level = '0; ib.auto_eoi = 1'b0; ib.auto_rotate = 1'b0;
    ib.eoi_valid = 1'b0; ib.eoi_cmd = '0; ib.eoi_level = '0; ib.special_mask = '0;
  endtask

  // One cycle of stimulus on the selected DUT plus the expected state after the next edge.
  task automatic step(input int sel, input bit r, input bit av, input int al, input bit ae,
                      input bit ar, input bit ev, input bit [2:0] c, input int el,
                      input logic [31:0] m, input logic [31:0] xi, input logic [31:0] xh,
                      input int xp, input bit xe, input bit xr, input string nm);
    exp_t e;
    @(negedge clock);
    reset = r;
    idle_a();
    idle_b();
    if (sel == 0) begin
      ia.ack_valid = av; ia.ack_level = 3'(al); ia.auto_eoi = ae; ia.auto_rotate = ar;
      ia.eoi_valid = ev; ia.eoi_cmd = c; ia.eoi_level = 3'(el); ia.special_mask = m[7:0];
    end else begin
      ib.ack_valid = av; ib.ack_level = 3'(al); ib.auto_eoi = ae; ib.auto_rotate = ar;
      ib.eoi_valid = ev; ib.eoi_cmd = c; ib.eoi_level = 3'(el); ib.special_mask = m[4:0];
    end
    e.sel = sel; e.isr = xi; e.hls = xh; e.ptr = 5'(xp); e.empty = xe; e.err = xr; e.name = nm;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=0x%0h expected=0x%0h", nm, f, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 0) begin
          chk(e.name, "isr",   32'(ia.in_service_register),      e.isr);
          chk(e.name, "hls",   32'(ia.highest_level_in_service), e.hls);
          chk(e.name, "ptr",   32'(ia.priority_pointer),         32'(e.ptr));
          chk(e.name, "empty", 32'(ia.isr_empty),                32'(e.empty));
          chk(e.name, "err",   32'(ia.cmd_error),                32'(e.err));
        end else begin
          chk(e.name, "isr",   32'(ib.in_service_register),      e.isr);
          chk(e.name, "hls",   32'(ib.highest_level_in_service), e.hls);
          chk(e.name, "ptr",   32'(ib.priority_pointer),         32'(e.ptr));
          chk(e.name, "empty", 32'(ib.isr_empty),                32'(e.empty));
          chk(e.name, "err",   32'(ib.cmd_error),                32'(e.err));
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    idle_a();
    idle_b();
    //   sel r  av al ae ar ev cmd     el m      isr    hls    ptr em er name
    step(0, 1, 0, 0, 0, 0, 0, 3'b000, 0, 32'h0, 32'h00, 32'h00, 7, 1, 0, "a_reset");
    step(0, 0, 1, 3, 0, 0, 0, 3'b000, 0, 32'h0, 32'h08, 32'h08, 7, 0, 0, "a_ack3");
    step(0, 0, 1, 5, 0, 0, 0, 3'b000, 0, 32'h0, 32'h28, 32'h08, 7, 0, 0, "a_ack5");
    step(0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 32'h0, 32'h20, 32'h20, 7, 0, 0, "a_nseoi");
    step(0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 32'h0, 32'h00, 32'h00, 7, 1, 0, "a_nseoi2");
    step(0, 0, 0, 0, 0, 0, 1, 3'b110, 4, 32'h0, 32'h00, 32'h00, 4, 1, 0, "a_setpri4");
    step(0, 0, 1, 2, 0, 0, 0, 3'b000, 0, 32'h0, 32'h04, 32'h04, 4, 0, 0, "a_ack2");
    step(0, 0, 1, 6, 0, 0, 0, 3'b000, 0, 32'h0, 32'h44, 32'h40, 4, 0, 0, "a_ack6");
    step(0, 0, 0, 0, 0, 0, 1, 3'b101, 0, 32'h0, 32'h04, 32'h04, 6, 0, 0, "a_rotns");
    step(0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 32'h0, 32'h00, 32'h00, 6, 1, 0, "a_nseoi3");
    step(0, 0, 1, 5, 1, 1, 0, 3'b000, 0, 32'h0, 32'h00, 32'h00, 5, 1, 0, "a_aeoi5");
    step(0, 0, 1, 4, 0, 0, 0, 3'b000, 0, 32'h0, 32'h10, 32'h10, 5, 0, 0, "a_ack4");
    step(0, 0, 1, 1, 0, 0, 1, 3'b001, 0, 32'h0, 32'h02, 32'h02, 5, 0, 0, "a_ack1_ns");
    step(0, 0, 0, 0, 0, 0, 1, 3'b011, 7, 32'h0, 32'h02, 32'h02, 5, 0, 1, "a_spunset");
    step(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 32'h0, 32'h02, 32'h02, 5, 0, 0, "a_errpulse");
    step(0, 0, 0, 0, 0, 0, 1, 3'b011, 1, 32'h0, 32'h00, 32'h00, 5, 1, 0, "a_speoi1");
    step(0, 0, 1, 2, 0, 0, 0, 3'b000, 0, 32'h0, 32'h04, 32'h04, 5, 0, 0, "a_ack2b");
    step(0, 0, 1, 3, 0, 0, 0, 3'b000, 0, 32'h4, 32'h0C, 32'h08, 5, 0, 0, "a_mask4");
    step(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 32'hC, 32'h0C, 32'h00, 5, 0, 0, "a_maskall");
    step(0, 0, 1, 3, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0C, 32'h04, 5, 0, 0, "a_reack3");
    step(0, 0, 1, 3, 0, 0, 1, 3'b011, 3, 32'h0, 32'h0C, 32'h04, 5, 0, 0, "a_ack_sp_same");
    step(0, 0, 0, 0, 0, 0, 1, 3'b111, 2, 32'h0, 32'h08, 32'h08, 2, 0, 0, "a_rotsp2");
    step(0, 0, 0, 0, 0, 0, 1, 3'b011, 3, 32'h0, 32'h00, 32'h00, 2, 1, 0, "a_speoi3");
    step(0, 0, 0, 0, 0, 0, 1, 3'b101, 0, 32'h0, 32'h00, 32'h00, 2, 1, 0, "a_rotns_empty");
    step(0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 32'h0, 32'h00, 32'h00, 2, 1, 0, "a_undef010");
    step(0, 0, 1, 5, 1, 1, 1, 3'b110, 1, 32'h0, 32'h00, 32'h00, 1, 1, 0, "a_eoi_wins");
    step(0, 0, 1, 0, 0, 0, 0, 3'b000, 0, 32'h0, 32'h01, 32'h01, 1, 0, 0, "a_ack0");
    step(0, 1, 0, 0, 0, 0, 1, 3'b001, 0, 32'h0, 32'h00, 32'h00, 7, 1, 0, "a_reset_eoi");
    step(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 32'h0, 32'h00, 32'h00, 7, 1, 0, "a_post_reset");
    step(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 32'h0, 32'h00, 32'h00, 4, 1, 0, "b_reset");
    step(1, 0, 0, 0, 0, 0, 1, 3'b110, 4, 32'h0, 32'h00, 32'h00, 4, 1, 0, "b_setpri4");
    step(1, 0, 1, 0, 0, 0, 0, 3'b000, 0, 32'h0, 32'h01, 32'h01, 4, 0, 0, "b_ack0");
    step(1, 0, 1, 3, 0, 0, 0, 3'b000, 0, 32'h0, 32'h09, 32'h01, 4, 0, 0, "b_ack3");
    step(1, 0, 1, 6, 0, 0, 0, 3'b000, 0, 32'h0, 32'h09, 32'h01, 4, 0, 1, "b_ack6_oob");
    step(1, 0, 0, 0, 0, 0, 1, 3'b110, 7, 32'h0, 32'h09, 32'h01, 4, 0, 1, "b_setpri7_oob");
    step(1, 0, 0, 0, 0, 0, 1, 3'b110, 2, 32'h0, 32'h09, 32'h08, 2, 0, 0, "b_setpri2");
    step(1, 0, 0, 0, 0, 0, 1, 3'b101, 0, 32'h0, 32'h01, 32'h01, 3, 0, 0, "b_rotns");
    step(1, 0, 1, 4, 1, 1, 0, 3'b000, 0, 32'h0, 32'h01, 32'h01, 4, 0, 0, "b_aeoi4");
    step(1, 0, 1, 4, 0, 0, 0, 3'b000, 0, 32'h0, 32'h11, 32'h01, 4, 0, 0, "b_ack4");
    step(1, 0, 0, 0, 0, 0, 1, 3'b111, 0, 32'h0, 32'h10, 32'h10, 0, 0, 0, "b_rotsp0");
    step(1, 0, 0, 0, 0, 0, 1, 3'b011, 5, 32'h0, 32'h10, 32'h10, 0, 0, 1, "b_sp5_oob");
    @(negedge clock);
    idle_a();
    idle_b();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
